// File: rtl/adc_acq_top_core.sv
// Per-channel ADC acquisition sequencer: header, then waveforms of packed sample words.
// Optional trailer word after the last data word when ADC_ACQ_TRAILER_EN is defined.
module adc_acq_top_core #(
  parameter int unsigned SAMP_W = 12
) (
  input  logic              adc_clk,
  input  logic              reset_n,
  input  logic [SAMP_W-1:0] adc_dat_a,
  input  logic [SAMP_W-1:0] adc_dat_b,
  input  logic              adc_ovr,
  input  logic [15:0]       channel_tag,
  input  logic [22:0]       num_muon_bursts,
  input  logic [22:0]       num_laser_bursts,
  input  logic [22:0]       num_ped_bursts,
  input  logic [23:0]       initial_fill_num,
  input  logic              initial_fill_num_wr,
  input  logic              acq_enable0,
  input  logic              acq_enable1,
  input  logic              acq_trig,
  input  logic              acq_reset,
  input  logic              ddr3_wr_done,
  input  logic [11:0]       num_waveforms,
  input  logic [21:0]       waveform_gap,
  input  logic              adc_buf_delay_data_reset,
  input  logic [4:0]        adc_buf_data_delay,
  output logic [64:0]       adc_buf_current_data_delay,
  output logic [23:0]       fill_num,
  output logic [127:0]      adc_acq_out_dat,
  output logic              adc_acq_out_valid,
  output logic              acq_done,
  output logic              adc_acq_full_reset,
  output logic              acq_enabled,
  output logic              adc_acq_sm_idl
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StHdr    = 3'd1;
  localparam logic [2:0] StSample = 3'd2;
  localparam logic [2:0] StGap    = 3'd3;
  localparam logic [2:0] StWaitWr = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;
`ifdef ADC_ACQ_TRAILER_EN
  localparam logic [2:0] StTrl    = 3'd4;
  localparam logic [2:0] StEnd    = StTrl;
`else
  localparam logic [2:0] StEnd    = StWaitWr;
`endif

  logic [2:0]  state_q, state_d;
  logic        trig_q, full_reset_q;
  logic [4:0]  tap_q;
  logic [23:0] fill_num_q;
  logic [1:0]  type_q;
  logic [22:0] n_q, word_cnt_q, n_sel;
  logic [11:0] nwfm_q, wfm_cnt_q;
  logic [21:0] gap_q, gap_cnt_q;
  logic [1:0]  phase_q;
  logic [95:0] pack_q;
  logic [15:0] lane_a, lane_b;
  logic        start, hdr_only, last_word, last_wfm, gap_end;
`ifdef ADC_ACQ_TRAILER_EN
  logic [23:0] tot_q;
`endif

  assign acq_enabled    = acq_enable1 | acq_enable0;
  assign lane_a         = {{(15 - SAMP_W){1'b0}}, adc_ovr, adc_dat_a};
  assign lane_b         = {{(15 - SAMP_W){1'b0}}, adc_ovr, adc_dat_b};
  assign start          = (state_q == StIdle) && acq_trig && !trig_q && acq_enabled && !acq_reset;
  assign hdr_only       = (n_q == 23'd0) || (nwfm_q == 12'd0);
  assign last_word      = (word_cnt_q == n_q - 23'd1);
  assign last_wfm       = (wfm_cnt_q == nwfm_q - 12'd1);
  assign gap_end        = (gap_cnt_q == gap_q - 22'd1);

  assign adc_buf_current_data_delay = {13{tap_q}};
  assign fill_num                   = fill_num_q;
  assign adc_acq_full_reset         = full_reset_q;
  assign acq_done                   = (state_q == StDone);
  assign adc_acq_sm_idl             = (state_q == StIdle);

  always_comb begin
    unique case ({acq_enable1, acq_enable0})
      2'b01:   n_sel = num_muon_bursts;
      2'b10:   n_sel = num_laser_bursts;
      2'b11:   n_sel = num_ped_bursts;
      default: n_sel = 23'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StHdr;
      StHdr:    state_d = hdr_only ? StEnd : StSample;
      StSample: begin
        if (phase_q == 2'd3 && last_word) begin
          if (last_wfm)                 state_d = StEnd;
          else if (gap_q == 22'd0)      state_d = StSample;
          else                          state_d = StGap;
        end
      end
      StGap:    if (gap_end) state_d = StSample;
`ifdef ADC_ACQ_TRAILER_EN
      StTrl:    state_d = StWaitWr;
`endif
      StWaitWr: if (ddr3_wr_done) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (acq_reset) state_d = StIdle;
  end

  // The fourth sample clock's pair is forwarded directly, so the word is valid in that clock.
  always_comb begin
    adc_acq_out_valid = 1'b0;
    adc_acq_out_dat   = '0;
    if (state_q == StHdr) begin
      adc_acq_out_valid = 1'b1;
      adc_acq_out_dat   = {fill_num_q, channel_tag, type_q, n_q, nwfm_q, gap_q, 29'd0};
    end else if (state_q == StSample && phase_q == 2'd3) begin
      adc_acq_out_valid = 1'b1;
      adc_acq_out_dat   = {lane_b, lane_a, pack_q};
`ifdef ADC_ACQ_TRAILER_EN
    end else if (state_q == StTrl) begin
      adc_acq_out_valid = 1'b1;
      adc_acq_out_dat   = {8'hEE, fill_num_q, 72'd0, tot_q};
`endif
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      trig_q       <= 1'b0;
      full_reset_q <= 1'b0;
      tap_q        <= '0;
      fill_num_q   <= '0;
      type_q       <= '0;
      n_q          <= '0;
      nwfm_q       <= '0;
      gap_q        <= '0;
      phase_q      <= '0;
      word_cnt_q   <= '0;
      wfm_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      pack_q       <= '0;
`ifdef ADC_ACQ_TRAILER_EN
      tot_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      trig_q       <= acq_trig;
      full_reset_q <= acq_reset;
      if (adc_buf_delay_data_reset) tap_q <= adc_buf_data_delay;
      if (initial_fill_num_wr)                      fill_num_q <= initial_fill_num;
      else if (state_q == StDone && !acq_reset)     fill_num_q <= fill_num_q + 24'd1;
      if (acq_reset) begin
        phase_q    <= '0;
        word_cnt_q <= '0;
        wfm_cnt_q  <= '0;
        gap_cnt_q  <= '0;
        pack_q     <= '0;
`ifdef ADC_ACQ_TRAILER_EN
        tot_q      <= '0;
`endif
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              type_q     <= {acq_enable1, acq_enable0};
              n_q        <= n_sel;
              nwfm_q     <= num_waveforms;
              gap_q      <= waveform_gap;
              phase_q    <= '0;
              word_cnt_q <= '0;
              wfm_cnt_q  <= '0;
              gap_cnt_q  <= '0;
`ifdef ADC_ACQ_TRAILER_EN
              tot_q      <= '0;
`endif
            end
          end
          StSample: begin
            phase_q   <= phase_q + 2'd1;
            pack_q    <= {lane_b, lane_a, pack_q[95:32]};
            gap_cnt_q <= '0;
            if (phase_q == 2'd3) begin
`ifdef ADC_ACQ_TRAILER_EN
              tot_q <= tot_q + 24'd1;
`endif
              if (last_word) begin
                word_cnt_q <= '0;
                wfm_cnt_q  <= wfm_cnt_q + 12'd1;
              end else begin
                word_cnt_q <= word_cnt_q + 23'd1;
              end
            end
          end
          StGap:   gap_cnt_q <= gap_cnt_q + 22'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_acq_top_core.sv
// Bench for adc_acq_top_core: schedule-based fill model checked every clock, plus literal pins.
module tb_adc_acq_top_core;

  logic         adc_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [11:0]  adc_dat_a = '0, adc_dat_b = '0;
  logic         adc_ovr = 1'b0;
  logic [15:0]  channel_tag = '0;
  logic [22:0]  num_muon_bursts = '0, num_laser_bursts = '0, num_ped_bursts = '0;
  logic [23:0]  initial_fill_num = '0;
  logic         initial_fill_num_wr = 1'b0;
  logic         acq_enable0 = 1'b0, acq_enable1 = 1'b0;
  logic         acq_trig = 1'b0, acq_reset = 1'b0, ddr3_wr_done = 1'b0;
  logic [11:0]  num_waveforms = '0;
  logic [21:0]  waveform_gap = '0;
  logic         adc_buf_delay_data_reset = 1'b0;
  logic [4:0]   adc_buf_data_delay = '0;
  logic [64:0]  adc_buf_current_data_delay;
  logic [23:0]  fill_num;
  logic [127:0] adc_acq_out_dat;
  logic         adc_acq_out_valid, acq_done, adc_acq_full_reset, acq_enabled, adc_acq_sm_idl;

  adc_acq_top_core #(.SAMP_W(12)) dut (
    .adc_clk                    (adc_clk),
    .reset_n                    (reset_n),
    .adc_dat_a                  (adc_dat_a),
    .adc_dat_b                  (adc_dat_b),
    .adc_ovr                    (adc_ovr),
    .channel_tag                (channel_tag),
    .num_muon_bursts            (num_muon_bursts),
    .num_laser_bursts           (num_laser_bursts),
    .num_ped_bursts             (num_ped_bursts),
    .initial_fill_num           (initial_fill_num),
    .initial_fill_num_wr        (initial_fill_num_wr),
    .acq_enable0                (acq_enable0),
    .acq_enable1                (acq_enable1),
    .acq_trig                   (acq_trig),
    .acq_reset                  (acq_reset),
    .ddr3_wr_done               (ddr3_wr_done),
    .num_waveforms              (num_waveforms),
    .waveform_gap               (waveform_gap),
    .adc_buf_delay_data_reset   (adc_buf_delay_data_reset),
    .adc_buf_data_delay         (adc_buf_data_delay),
    .adc_buf_current_data_delay (adc_buf_current_data_delay),
    .fill_num                   (fill_num),
    .adc_acq_out_dat            (adc_acq_out_dat),
    .adc_acq_out_valid          (adc_acq_out_valid),
    .acq_done                   (acq_done),
    .adc_acq_full_reset         (adc_acq_full_reset),
    .acq_enabled                (acq_enabled),
    .adc_acq_sm_idl             (adc_acq_sm_idl)
  );

  always #5 adc_clk = ~adc_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ri = 0;
  bit ramp_on = 1'b0;
  int n_done_seen = 0;
  logic [127:0] got_q[$];

  logic [11:0] ha[8192];
  logic [11:0] hb[8192];
  logic        ho[8192];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // New cycle: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge adc_clk);
    #1;
    if (ramp_on) begin
      adc_dat_a = 12'(2 * ri);
      adc_dat_b = 12'(2 * ri + 1);
      adc_ovr   = (ri == 1);
      ri++;
    end
  endtask

  function automatic logic [127:0] mk_word(input int c);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      w[32*i +: 16]      = {3'b000, ho[c-3+i], ha[c-3+i]};
      w[32*i + 16 +: 16] = {3'b000, ho[c-3+i], hb[c-3+i]};
    end
    return w;
  endfunction

  // Fill model: outputs derived from cycle offsets relative to the trigger edge.
  initial begin : model
    bit           fill_on, prev_trig, prev_rst, act, ev;
    int           t0, n_i, w_i, g_i, data_end, wait_start, done_cyc, off, k, p, r;
    logic [1:0]   mtype;
    logic [23:0]  fm;
    logic [4:0]   tap_m;
    logic [127:0] ed;
    fill_on = 0; prev_trig = 0; prev_rst = 0; fm = '0; tap_m = '0;
    t0 = 0; n_i = 0; w_i = 0; g_i = 0; data_end = 0; wait_start = 0; done_cyc = -1;
    mtype = '0;
    forever begin
      @(negedge adc_clk);
      if (!reset_n) begin
        fill_on = 0; prev_trig = 0; prev_rst = 0; fm = '0; tap_m = '0;
      end else if (cyc < 8192) begin
        ha[cyc] = adc_dat_a; hb[cyc] = adc_dat_b; ho[cyc] = adc_ovr;
        act = fill_on && (cyc > t0);
        ev = 1'b0;
        ed = '0;
        if (act) begin
          off = cyc - t0;
          if (off == 1) begin
            ev = 1'b1;
            ed = {fm, channel_tag, mtype, 23'(n_i), 12'(w_i), 22'(g_i), 29'd0};
          end else if (cyc < data_end) begin
            k = off - 2;
            p = 4 * n_i + g_i;
            r = k % p;
            if (r < 4 * n_i && (r % 4) == 3) begin
              ev = 1'b1;
              ed = mk_word(cyc);
            end
`ifdef ADC_ACQ_TRAILER_EN
          end else if (cyc == data_end) begin
            ev = 1'b1;
            ed = {8'hEE, fm, 72'd0, 24'(n_i * w_i)};
`endif
          end
        end
        chk("valid", 128'(adc_acq_out_valid), 128'(ev));
        if (ev) chk("data", adc_acq_out_dat, ed);
        chk("acq_done", 128'(acq_done), 128'(act && cyc == done_cyc));
        chk("sm_idl", 128'(adc_acq_sm_idl), 128'(!act));
        chk("fill_num", 128'(fill_num), 128'(fm));
        chk("full_reset", 128'(adc_acq_full_reset), 128'(prev_rst));
        chk("enabled", 128'(acq_enabled), 128'(acq_enable0 | acq_enable1));
        chk("tap", 128'(adc_buf_current_data_delay), 128'({13{tap_m}}));
        if (adc_acq_out_valid) got_q.push_back(adc_acq_out_dat);
        if (acq_done) n_done_seen++;
        // End-of-cycle model updates.
        if (act && done_cyc < 0 && cyc >= wait_start && ddr3_wr_done) done_cyc = cyc + 1;
        if (initial_fill_num_wr) fm = initial_fill_num;
        else if (act && cyc == done_cyc && !acq_reset) fm = fm + 24'd1;
        if (act && (cyc == done_cyc || acq_reset)) fill_on = 0;
        if (!act && acq_trig && !prev_trig && (acq_enable0 | acq_enable1) && !acq_reset) begin
          fill_on = 1; t0 = cyc; done_cyc = -1;
          mtype = {acq_enable1, acq_enable0};
          n_i = (mtype == 2'b01) ? int'(num_muon_bursts) :
                (mtype == 2'b10) ? int'(num_laser_bursts) : int'(num_ped_bursts);
          w_i = int'(num_waveforms);
          g_i = int'(waveform_gap);
          if (n_i == 0 || w_i == 0) data_end = t0 + 2;
          else data_end = t0 + 2 + w_i * (4 * n_i + g_i) - g_i;
`ifdef ADC_ACQ_TRAILER_EN
          wait_start = data_end + 1;
`else
          wait_start = data_end;
`endif
        end
        if (adc_buf_delay_data_reset) tap_m = adc_buf_data_delay;
        prev_trig = acq_trig;
        prev_rst  = acq_reset;
      end
      cyc++;
    end
  end

  initial begin : stim
    int           base, dbase;
    logic [127:0] lit;
    repeat (3) tick();
    @(negedge adc_clk);
    chk("rst_valid", 128'(adc_acq_out_valid), 128'd0);
    chk("rst_dat", adc_acq_out_dat, 128'd0);
    chk("rst_done", 128'(acq_done), 128'd0);
    chk("rst_fill", 128'(fill_num), 128'd0);
    chk("rst_tap", 128'(adc_buf_current_data_delay), 128'd0);
    chk("rst_full_reset", 128'(adc_acq_full_reset), 128'd0);
    chk("rst_idle", 128'(adc_acq_sm_idl), 128'd1);

    tick(); reset_n = 1'b1;
    tick(); initial_fill_num = 24'h55; initial_fill_num_wr = 1'b1;
    tick(); initial_fill_num_wr = 1'b0;
    adc_buf_data_delay = 5'h13; adc_buf_delay_data_reset = 1'b1;
    tick(); adc_buf_delay_data_reset = 1'b0;
    @(negedge adc_clk);
    chk("load_fill", 128'(fill_num), 128'h55);
    lit = 128'({13{5'h13}});
    chk("tap_latch", 128'(adc_buf_current_data_delay), lit);
    chk("load_valid", 128'(adc_acq_out_valid), 128'd0);

    // Muon fill with a ramp on the inputs; trigger held high for the whole fill.
    acq_enable0 = 1'b1; acq_enable1 = 1'b0;
    num_muon_bursts = 23'd5; num_laser_bursts = 23'd2; num_ped_bursts = 23'h0B;
    num_waveforms = 12'd3; waveform_gap = 22'd1; channel_tag = 16'h0008;
    ramp_on = 1'b1;
    tick(); tick();
    ri = -2;
    tick(); acq_trig = 1'b1;
    base = got_q.size(); dbase = n_done_seen;
    repeat (70) tick();
    ddr3_wr_done = 1'b1;
    tick(); ddr3_wr_done = 1'b0;
    repeat (5) tick();
    @(negedge adc_clk);
    chk("muon_words", 128'(got_q.size() - base), 128'd16);
    lit = {24'h000055, 16'h0008, 2'b01, 23'd5, 12'd3, 22'd1, 29'd0};
    if (got_q.size() > base) chk("muon_header", got_q[base], lit);
    lit = 128'h0007_0006_0005_0004_1003_1002_0001_0000;
    if (got_q.size() > base + 1) chk("ramp_word0", got_q[base+1], lit);
    lit = 128'h000F_000E_000D_000C_000B_000A_0009_0008;
    if (got_q.size() > base + 2) chk("ramp_word1", got_q[base+2], lit);
    lit = 128'h0031_0030_002F_002E_002D_002C_002B_002A;
    if (got_q.size() > base + 6) chk("wfm1_word0", got_q[base+6], lit);
    chk("muon_done", 128'(n_done_seen - dbase), 128'd1);
    chk("muon_fill_inc", 128'(fill_num), 128'h56);

    // Disabled: a trigger edge must produce nothing.
    tick(); acq_trig = 1'b0; acq_enable0 = 1'b0;
    tick(); acq_trig = 1'b1;
    base = got_q.size();
    repeat (20) tick();
    @(negedge adc_clk);
    chk("off_words", 128'(got_q.size() - base), 128'd0);
    chk("off_idle", 128'(adc_acq_sm_idl), 128'd1);

    // Laser fill with zero gap: waveforms run back to back.
    tick(); acq_trig = 1'b0; acq_enable1 = 1'b1; num_waveforms = 12'd2; waveform_gap = 22'd0;
    tick(); acq_trig = 1'b1;
    base = got_q.size();
    repeat (25) tick();
    ddr3_wr_done = 1'b1;
    tick(); ddr3_wr_done = 1'b0;
    repeat (4) tick();
    @(negedge adc_clk);
    chk("laser_words", 128'(got_q.size() - base), 128'd5);
    chk("laser_fill_inc", 128'(fill_num), 128'h57);

    // Abort mid-sample with acq_reset.
    tick(); acq_trig = 1'b0;
    tick(); acq_trig = 1'b1;
    base = got_q.size();
    repeat (6) tick();
    acq_reset = 1'b1;
    tick(); acq_reset = 1'b0;
    @(negedge adc_clk);
    chk("abort_idle", 128'(adc_acq_sm_idl), 128'd1);
    chk("abort_valid", 128'(adc_acq_out_valid), 128'd0);
    chk("abort_full_reset", 128'(adc_acq_full_reset), 128'd1);
    repeat (20) tick();
    @(negedge adc_clk);
    chk("abort_words", 128'(got_q.size() - base), 128'd2);
    chk("abort_fill_kept", 128'(fill_num), 128'h57);

    // Pedestal header-only fill; writer already done on entry to the wait.
    tick(); acq_trig = 1'b0; acq_enable0 = 1'b1; acq_enable1 = 1'b1;
    num_waveforms = 12'd0; waveform_gap = 22'd5; ddr3_wr_done = 1'b1;
    tick(); acq_trig = 1'b1;
    base = got_q.size(); dbase = n_done_seen;
    repeat (8) tick();
    ddr3_wr_done = 1'b0; acq_trig = 1'b0;
    repeat (2) tick();
    @(negedge adc_clk);
`ifdef ADC_ACQ_TRAILER_EN
    chk("ped_words", 128'(got_q.size() - base), 128'd2);
`else
    chk("ped_words", 128'(got_q.size() - base), 128'd1);
`endif
    lit = {24'h000057, 16'h0008, 2'b11, 23'h00000B, 12'd0, 22'd5, 29'd0};
    if (got_q.size() > base) chk("ped_header", got_q[base], lit);
    chk("ped_done", 128'(n_done_seen - dbase), 128'd1);
    chk("ped_fill_inc", 128'(fill_num), 128'h58);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
